pow2_div_arbiter: RTL and testbench

//  Shares one power-of-two divide/remainder datapath (Div = m >> n, Rem = m mod 2^n)

---
 rtl/pow2_div_arbiter.sv | 81 ++++++++
 tb/tb_pow2_div_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pow2_div_arbiter.sv
// pow2_div_arbiter: round-robin two-client front end for a one-stage shift/mask power-of-two divider
module pow2_div_arbiter #(
  parameter int DW = 16,
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic [DW-1:0] a_m,
  input  logic [SW-1:0] a_n,
  output logic          a_gnt,
  input  logic          b_req,
  input  logic [DW-1:0] b_m,
  input  logic [SW-1:0] b_n,
  output logic          b_gnt,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_div,
  output logic [DW-1:0] res_rem,
  output logic          res_tag
);
  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;
  state_t state_q, state_d;
  logic last_tag_q, last_tag_d;
  logic op_tag_q, op_tag_d;
  logic [DW-1:0] op_m_q, op_m_d;
  logic [SW-1:0] op_n_q, op_n_d;
  logic res_valid_q, res_valid_d;
  logic [DW-1:0] res_div_q, res_div_d;
  logic [DW-1:0] res_rem_q, res_rem_d;
  logic res_tag_q, res_tag_d;
  logic gnt_ok;
  // grant only while the result slot is empty or being emptied; ties go to the side not served last
  always_comb begin
    gnt_ok = !rst && (state_q == IDLE || (state_q == HOLD && res_ready));
    a_gnt = gnt_ok && a_req && (!b_req || last_tag_q);
    b_gnt = gnt_ok && b_req && (!a_req || !last_tag_q);
  end
  // next state, operand capture on grant, result computed from captured operands in CALC
  always_comb begin
    state_d = (a_gnt || b_gnt) ? CALC
            : state_q == CALC ? HOLD
            : (state_q == HOLD && res_ready) ? IDLE : state_q;
    last_tag_d = (a_gnt || b_gnt) ? b_gnt : last_tag_q;
    op_tag_d = (a_gnt || b_gnt) ? b_gnt : op_tag_q;
    op_m_d = a_gnt ? a_m : b_gnt ? b_m : op_m_q;
    op_n_d = a_gnt ? a_n : b_gnt ? b_n : op_n_q;
    res_valid_d = state_q == CALC ? 1'b1 : (state_q == HOLD && res_ready) ? 1'b0 : res_valid_q;
    res_div_d = state_q == CALC ? op_m_q >> op_n_q : res_div_q;
    res_rem_d = state_q == CALC ? op_m_q & ~({DW{1'b1}} << op_n_q) : res_rem_q;
    res_tag_d = state_q == CALC ? op_tag_q : res_tag_q;
  end
  // state and result registers; reset drops any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_tag_q <= 1'b1;
      op_tag_q <= 1'b0;
      op_m_q <= '0;
      op_n_q <= '0;
      res_valid_q <= 1'b0;
      res_div_q <= '0;
      res_rem_q <= '0;
      res_tag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_tag_q <= last_tag_d;
      op_tag_q <= op_tag_d;
      op_m_q <= op_m_d;
      op_n_q <= op_n_d;
      res_valid_q <= res_valid_d;
      res_div_q <= res_div_d;
      res_rem_q <= res_rem_d;
      res_tag_q <= res_tag_d;
    end
  end
  assign res_valid = res_valid_q;
  assign res_div = res_div_q;
  assign res_rem = res_rem_q;
  assign res_tag = res_tag_q;
endmodule

// File: tb/tb_pow2_div_arbiter.sv
// tb_pow2_div_arbiter: directed and randomized scoreboard checks of the shared divider arbiter
module tb_pow2_div_arbiter;
  logic clk = 0, rst = 1;
  logic a_req = 0, b_req = 0, res_ready = 0;
  logic [15:0] a_m = 0, b_m = 0;
  logic [3:0] a_n = 0, b_n = 0;
  logic a_gnt, b_gnt, res_valid, res_tag;
  logic [15:0] res_div, res_rem;
  int total = 0, bad = 0;
  logic [32:0] exp_q[$];
  pow2_div_arbiter #(.DW(16), .SW(4)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_m(a_m), .a_n(a_n), .a_gnt(a_gnt),
    .b_req(b_req), .b_m(b_m), .b_n(b_n), .b_gnt(b_gnt),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_div(res_div), .res_rem(res_rem), .res_tag(res_tag)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic single(input logic side, input logic [15:0] m, input logic [3:0] n,
                        input logic [15:0] ed, input logic [15:0] er);
    if (side) begin b_req = 1; b_m = m; b_n = n; end
    else begin a_req = 1; a_m = m; a_n = n; end
    #1;
    chk("single_gnt", {30'd0, a_gnt, b_gnt}, side ? 32'd1 : 32'd2);
    tick();
    a_req = 0; b_req = 0;
    #1;
    chk("single_calc_nognt", {30'd0, a_gnt, b_gnt}, 0);
    chk("single_calc_valid", res_valid, 0);
    tick();
    chk("single_valid", res_valid, 1);
    chk("single_div", res_div, ed);
    chk("single_rem", res_rem, er);
    chk("single_tag", res_tag, side);
    res_ready = 1;
    tick();
    chk("single_drain", res_valid, 0);
    res_ready = 0;
  endtask
  initial begin
    logic [15:0] hd, hr;
    logic ht, pa, pb, ag, bg, v, r;
    logic [32:0] e;
    #1;
    chk("rst_valid", res_valid, 0);
    chk("rst_div", res_div, 0);
    chk("rst_rem", res_rem, 0);
    chk("rst_tag", res_tag, 0);
    a_req = 1; b_req = 1;
    #1;
    chk("rst_gnt", {30'd0, a_gnt, b_gnt}, 0);
    a_req = 0; b_req = 0;
    tick();
    rst = 0;
    tick();
    single(0, 16'hABCD, 4, 16'h0ABC, 16'h000D);
    single(1, 16'h1234, 0, 16'h1234, 16'h0000);
    single(1, 16'hFFFF, 15, 16'h0001, 16'h7FFF);
    single(1, 16'h0000, 7, 16'h0000, 16'h0000);
    single(0, 16'h8001, 15, 16'h0001, 16'h0001);
    single(1, 16'hBEEF, 8, 16'h00BE, 16'h00EF);
    // continuous contention: last grant was B, so A first, then alternating every 2 cycles
    a_m = 16'h00F0; a_n = 4; b_m = 16'h0107; b_n = 8;
    a_req = 1; b_req = 1; res_ready = 1;
    #1;
    chk("rr_first_gnt", {30'd0, a_gnt, b_gnt}, 2);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rr_calc_valid", res_valid, 0);
      chk("rr_calc_nognt", {30'd0, a_gnt, b_gnt}, 0);
      tick();
      chk("rr_valid", res_valid, 1);
      chk("rr_tag", res_tag, i % 2);
      chk("rr_div", res_div, (i % 2) ? 16'h0001 : 16'h000F);
      chk("rr_rem", res_rem, (i % 2) ? 16'h0007 : 16'h0000);
      chk("rr_next_gnt", {30'd0, a_gnt, b_gnt}, (i % 2) ? 32'd2 : 32'd1);
    end
    // stall with both pending: result frozen, no grants
    res_ready = 0;
    #1;
    chk("stall_nognt0", {30'd0, a_gnt, b_gnt}, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", res_valid, 1);
      chk("stall_tag", res_tag, 1);
      chk("stall_div", res_div, 16'h0001);
      chk("stall_rem", res_rem, 16'h0007);
      chk("stall_nognt", {30'd0, a_gnt, b_gnt}, 0);
    end
    res_ready = 1;
    #1;
    chk("release_gnt", {30'd0, a_gnt, b_gnt}, 2);
    tick();
    chk("release_calc", res_valid, 0);
    tick();
    chk("release_valid", res_valid, 1);
    chk("release_tag", res_tag, 0);
    a_req = 0; b_req = 0;
    tick();
    chk("release_idle", res_valid, 0);
    // reset in CALC after an A grant; reset must restore A-first priority
    res_ready = 0; b_req = 1; b_m = 16'h0055; b_n = 2;
    #1;
    chk("pre_rst_gnt", {30'd0, a_gnt, b_gnt}, 1);
    tick();
    b_req = 0; a_req = 1; a_m = 16'h0F0F; a_n = 3;
    tick();
    tick();
    res_ready = 1;
    #1;
    chk("pre_rst_gnt_a", {30'd0, a_gnt, b_gnt}, 2);
    tick();
    a_req = 1; b_req = 1; res_ready = 0;
    #1;
    rst = 1;
    #1;
    chk("rst_calc_valid", res_valid, 0);
    chk("rst_calc_div", res_div, 0);
    chk("rst_calc_gnt", {30'd0, a_gnt, b_gnt}, 0);
    tick();
    chk("rst_hold_valid", res_valid, 0);
    rst = 0;
    #1;
    chk("post_rst_gnt", {30'd0, a_gnt, b_gnt}, 2);
    tick();
    a_req = 0; b_req = 0;
    tick();
    chk("post_rst_valid", res_valid, 1);
    chk("post_rst_tag", res_tag, 0);
    chk("post_rst_div", res_div, 16'h01E1);
    chk("post_rst_rem", res_rem, 16'h0007);
    res_ready = 1;
    tick();
    // random traffic against a divide/modulo reference
    pa = 0; pb = 0;
    for (int c = 0; c < 10000; c++) begin
      if (!a_req || pa) begin a_req = $urandom_range(0, 1); a_m = 16'($urandom); a_n = 4'($urandom); end
      if (!b_req || pb) begin b_req = $urandom_range(0, 1); b_m = 16'($urandom); b_n = 4'($urandom); end
      res_ready = ($urandom_range(0, 3) != 0);
      #1;
      ag = a_gnt; bg = b_gnt; v = res_valid; r = res_ready;
      chk("rnd_one_gnt", {31'd0, ag & bg}, 0);
      if (v && r) begin
        if (exp_q.size() == 0) chk("rnd_spurious", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("rnd_tag", res_tag, e[32]);
          chk("rnd_div", res_div, e[31:16]);
          chk("rnd_rem", res_rem, e[15:0]);
        end
      end
      if (ag || bg) begin
        hd = 16'((ag ? int'(a_m) : int'(b_m)) / (1 << (ag ? a_n : b_n)));
        hr = 16'((ag ? int'(a_m) : int'(b_m)) % (1 << (ag ? a_n : b_n)));
        ht = bg;
        exp_q.push_back({ht, hd, hr});
      end
      pa = ag; pb = bg;
      tick();
    end
    a_req = 0; b_req = 0; res_ready = 1;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (res_valid) begin
        if (exp_q.size() == 0) chk("drain_spurious", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("drain_tag", res_tag, e[32]);
          chk("drain_div", res_div, e[31:16]);
          chk("drain_rem", res_rem, e[15:0]);
        end
      end
      tick();
    end
    chk("lost_results", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
